// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbiter feeding one registered valid/ready stage.
// MODE 0 is fixed priority (index 0 first), MODE 1 is round-robin.
module rr_arb_mux #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int MODE  = 1,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in,
  input  logic [N-1:0]       req,
  output logic [N-1:0]       grant,
  output logic [WIDTH-1:0]   out,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] ch [N];

  for (genvar j = 0; j < N; j++) begin : g_ch
    assign ch[j] = in[j*WIDTH +: WIDTH];
  end

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] win, cand;
  logic             found, accept, load;

  function automatic logic [IDX_W-1:0] step_idx(
    input logic [IDX_W-1:0] base,
    input int               k
  );
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Scan from ptr upward with wrap; MODE 0 always scans from 0.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = (MODE == 1) ? step_idx(ptr_q, k) : IDX_W'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign accept = ~vld_q | out_ready;
  assign load   = rst_n & accept & found;

  always_comb begin
    grant = '0;
    for (int j = 0; j < N; j++) begin
      grant[j] = load && (win == IDX_W'(j));
    end
  end

  always_comb begin
    out_d = out_q;
    idx_d = idx_q;
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (accept) begin
      vld_d = found;
      if (found) begin
        out_d = ch[win];
        idx_d = win;
        if (MODE == 1) begin
          ptr_d = (win == IDX_W'(N-1)) ? '0 : win + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      out_q <= out_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_idx   = idx_q;
  assign out_valid = vld_q;

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Clocked N-channel arbitrating multiplexer. Selects one requester per accepted cycle and registers its data into a single valid/ready output stage.
- MODE selects fixed-priority (lowest index wins) or round-robin fairness.
- Sits between multiple producer channels and one shared downstream consumer. It is the sequential, back-pressure-aware successor to the team's combinational priority mux.

Parameters:
- WIDTH, 4, data bits per channel.
- N, 4, number of requesting channels (N >= 1).
- MODE, 1, arbitration mode: 0 = fixed priority (index 0 highest), 1 = round-robin.
- IDX_W, (N>1 ? $clog2(N) : 1), width of the channel index. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  N*WIDTH  flattened channel data; channel j occupies bits [(j+1)*WIDTH-1 : j*WIDTH].
- req  input  N  per-channel request. The source holds req and its data stable until granted.
- grant  output  N  one-hot combinational accept. The channel is consumed this cycle. All zero when nothing is accepted.
- out  output  WIDTH  registered data of the last accepted channel.
- out_idx  output  IDX_W  registered index of the channel held in out.
- out_valid  output  1  out/out_idx hold an unconsumed word.
- out_ready  input  1  downstream accepts out this cycle when out_valid=1.

Behaviour:
- Reset (async, rst_n=0): out=0, out_idx=0, out_valid=0, rr pointer ptr=0. grant=0 while rst_n=0.
- accept = ~out_valid | out_ready. The stage can load whenever it is empty or being drained in the same cycle. This gives full throughput with no bubble.
- Winner selection (combinational, from req and ptr):
  - MODE=0: lowest set index of req.
  - MODE=1: first set index scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap mod N).
- grant = accept && (req != 0) ? one-hot(winner) : 0. At most one bit is ever set.
- Rising edge with accept=1 and req!=0:
  - out <= in slice of winner; out_idx <= winner; out_valid <= 1.
  - MODE=1 only: ptr <= (winner == N-1) ? 0 : winner + 1.
- Rising edge with accept=1 and req=0: out_valid <= 0. out and out_idx keep their last values. ptr is unchanged.
- Rising edge with accept=0 (out_valid=1, out_ready=0): out, out_idx, out_valid and ptr all hold. grant=0, so no requester is consumed. This is back-pressure stall.
- Latency: data granted in cycle t appears on out with out_valid=1 in cycle t+1.
- In MODE=0, ptr stays 0 and is unused.
- N=1: the winner is always 0. ptr stays 0. out_idx is 1 bit wide and reads 0.
- Fairness (MODE=1): with all N requesters continuously asserted and out_ready=1, grants rotate 0,1,...,N-1,0,... Each channel is served exactly once per N accepts.
- Simultaneous drain and load: with out_valid=1 and out_ready=1 in the same cycle as a new req, the old word is consumed and the new word loads on the same edge. out_valid stays 1.
- A req that is deasserted before grant is simply dropped from arbitration. No state is retained for it.
- Reset mid-operation clears out_valid immediately (asynchronously). Any in-flight word is discarded. ptr returns to 0.
- Data, once registered, is unaffected by later changes to the in or req inputs.

Test Plan:
- Reset/idle: hold rst_n=0, then release with req=0 and out_ready=1 -> out=0, out_valid=0, grant=0 for 5 cycles.
- MODE=1 rotation: WIDTH=4, N=4, in={4'hD,4'hC,4'hB,4'hA}, req=4'b1111, out_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001; out_idx one cycle later 0,1,2,3,0; out values A,B,C,D,A.
- MODE=0 priority: same stimulus with MODE=0 -> grant stays 0001 every cycle; out=A, out_idx=0 continuously.
- Back-pressure: load channel 2 (out=C, out_valid=1), then out_ready=0 for 3 cycles with req=4'b1011 -> grant=0, out=C, out_idx=2 held. Raise out_ready -> same cycle grant=1000 (ptr=3), next cycle out=D, out_idx=3.
- Wrap and skip: MODE=1, ptr=3 (after a grant to channel 2), req=4'b0101 -> grant=0001 (wrap past 3); next req=4'b0101 -> grant=0100; ptr ends at 3.
- Async reset mid-stream: out_valid=1 with out=B, assert rst_n=0 between clock edges -> out_valid=0 and out=0 immediately. After release, with req=4'b1111, the first grant is 0001.
